sub_word_rcon: RTL and testbench
================================

SUB_WORD_RCON -- requirements
Module: sub_word_rcon

Interface
REQ-001 Parameters: none; all widths are fixed.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 en  input  1  request strobe; sample state and r this cycle.
REQ-005 state  input  32  word to substitute; RotWord is already applied by the caller.
REQ-006 r  input  4  round index; legal range 1..10.
REQ-007 state_out  output  32  registered SubWord(state).
REQ-008 rcon  output  32  registered round constant {rc, 24'h000000}.
REQ-009 out_valid  output  1  high for one cycle when state_out/rcon hold a fresh result.

Function
REQ-010 SubWord: each byte of state is replaced independently by the AES forward S-box (FIPS-197 Fig. 7); byte lanes keep their positions ([31:24] to [31:24], etc.).
REQ-011 Rcon table, r to rc: 1 to 01, 2 to 02, 3 to 04, 4 to 08, 5 to 10, 6 to 20, 7 to 40, 8 to 80, 9 to 1B, 10 to 36 (hex).
REQ-012 r = 0 or r = 11..15 gives rc = 00; no error flag is raised.
REQ-013 rcon[23:0] is always zero.
REQ-014 Latency is exactly 1 cycle: with en=1 at rising edge N, state_out, rcon and out_valid=1 are visible after edge N.
REQ-015 With en=0 at an edge, state_out and rcon hold their previous values and out_valid goes to 0.
REQ-016 Back-to-back en=1 on consecutive cycles gives one result per cycle (full throughput, no stall, no backpressure).
REQ-017 S-box and Rcon lookups are purely combinational ahead of the output registers; no other pipeline stage exists.
REQ-018 Inputs are sampled only on edges where en=1; X on state or r while en=0 does not affect outputs.

Reset
REQ-019 When rst_n=0, state_out, rcon and out_valid clear to 0 immediately, without waiting for a clock edge.
REQ-020 Reset asserted mid-operation discards any in-flight request; no result is presented for it.
REQ-021 The first en=1 edge after rst_n deasserts produces a normal result one cycle later.

Structure
REQ-022 The shared package holds the 256-entry S-box constant table and the 10-entry Rcon constant table.
REQ-023 The package also holds a function returning rc for a 4-bit index, including the zero default.
REQ-024 One sub-module, sbox, maps 8 bits to 8 bits combinationally and is instantiated four times, once per byte lane.
REQ-025 The top level contains only the four sbox instances, the Rcon lookup, and the output registers.

Verification
REQ-026 Reset: assert rst_n=0 mid-cycle with en=1 -> all outputs 0 before the next clk edge; out_valid stays 0 until the first en=1 after release.
REQ-027 S-box spot check: state=00_01_53_FF, en=1 -> next cycle state_out=63_7C_ED_16, out_valid=1.
REQ-028 FIPS-197 key schedule word: state=CF4F3C09, r=1 -> state_out=8A84EB01, rcon=01000000.
REQ-029 Rcon sweep: r=0..15 back-to-back with en=1 -> rcon[31:24] = 00,01,02,04,08,10,20,40,80,1B,36,00,00,00,00,00; out_valid continuously 1.
REQ-030 Hold: one en=1 request followed by en=0 with random state/r -> outputs unchanged, out_valid=0.
REQ-031 Exhaustive: all 256 values replicated across the four byte lanes -> every lane matches the reference S-box table.

Source files
------------

// File: rtl/sub_word_rcon_pkg.sv
// Shared constants for the AES key-expansion SubWord/Rcon block:
// forward S-box table, round-constant table and the round-constant lookup.
package sub_word_rcon_pkg;

    localparam int NUM_ROUNDS = 10;

    // AES forward S-box, indexed by the input byte.
    localparam logic [7:0] SBOX_TABLE [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Round constants for rounds 1..10 (entry 0 is round 1).
    localparam logic [7:0] RCON_TABLE [0:NUM_ROUNDS-1] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    // Round constant for a 4-bit round index; indices outside 1..10 yield zero.
    function automatic logic [7:0] rc_lookup(input logic [3:0] r);
        logic [3:0] idx;
        idx = r - 4'd1;
        if (r >= 4'd1 && r <= 4'd10) begin
            return RCON_TABLE[idx];
        end
        return 8'h00;
    endfunction

endpackage

// File: rtl/sub_word_rcon_sbox.sv
// Single-byte AES forward S-box, purely combinational table lookup.
module sbox
    import sub_word_rcon_pkg::*;
(
    input  logic [7:0] val,
    output logic [7:0] sub
);

    assign sub = SBOX_TABLE[val];

endmodule

// File: rtl/sub_word_rcon.sv
// SubWord plus round-constant lookup for AES key expansion.
// One registered stage: the table lookups feed the output registers directly.
module sub_word_rcon
    import sub_word_rcon_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [31:0] state,
    input  logic [3:0]  r,
    output logic [31:0] state_out,
    output logic [31:0] rcon,
    output logic        out_valid
);

    // ---- stage p0: combinational lookups on the raw inputs ----
    logic [31:0] sub_p0;
    logic [7:0]  rc_p0;

    for (genvar lane = 0; lane < 4; lane++) begin : g_lane
        sbox u_sbox (
            .val (state[8*lane +: 8]),
            .sub (sub_p0[8*lane +: 8])
        );
    end

    assign rc_p0 = rc_lookup(r);

    // ---- stage p1: output registers ----
    // Capture a fresh result on en; otherwise hold data and drop the valid flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_out <= 32'h0;
            rcon      <= 32'h0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= en;
            if (en) begin
                state_out <= sub_p0;
                rcon      <= {rc_p0, 24'h000000};
            end
        end
    end

endmodule

// File: tb/tb_sub_word_rcon.sv
// Directed bench for sub_word_rcon: reset, spot vectors, Rcon sweep,
// hold behaviour, async reset mid-request and an all-bytes S-box pass.
module tb_sub_word_rcon;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [31:0] state;
    logic [3:0]  r;
    logic [31:0] state_out;
    logic [31:0] rcon;
    logic        out_valid;

    int tests;
    int fails;

    logic [7:0] ref_tab [0:255];
    logic [7:0] rc_exp  [0:15];

    sub_word_rcon dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .state     (state),
        .r         (r),
        .state_out (state_out),
        .rcon      (rcon),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // GF(2^8) multiply with the AES polynomial.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
        return (b << k) | (b >> (8 - k));
    endfunction

    // Reference S-box built from the multiplicative inverse and affine map.
    function automatic logic [7:0] calc_sbox(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h00;
        if (x != 8'h00) begin
            for (int i = 1; i < 256; i++) begin
                if (gmul(x, 8'(i)) == 8'h01) inv = 8'(i);
            end
        end
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample just after the rising edge.
    task automatic step(input logic e, input logic [31:0] s, input logic [3:0] rr);
        en    = e;
        state = s;
        r     = rr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] held_state;
        logic [31:0] held_rcon;
        logic [31:0] w;

        tests = 0;
        fails = 0;
        rc_exp = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
                   8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 256; i++) ref_tab[i] = calc_sbox(8'(i));

        rst_n = 1'b0;
        en    = 1'b0;
        state = 32'h0;
        r     = 4'd0;
        #12;
        check("reset_state_out", state_out, 32'h0);
        check("reset_rcon",      rcon,      32'h0);
        check("reset_valid",     {31'h0, out_valid}, 32'h1 - 32'h1);

        rst_n = 1'b1;
        step(1'b0, 32'h0, 4'd0);
        check("idle_valid", {31'h0, out_valid}, 32'h0);

        // S-box spot check
        step(1'b1, 32'h0001_53ff, 4'd1);
        check("spot_state_out", state_out, 32'h637c_ed16);
        check("spot_valid",     {31'h0, out_valid}, 32'h1);
        check("spot_rcon",      rcon, 32'h0100_0000);

        // Key-schedule word, round 1
        step(1'b1, 32'hcf4f_3c09, 4'd1);
        check("fips_state_out", state_out, 32'h8a84_eb01);
        check("fips_rcon",      rcon, 32'h0100_0000);

        // Rcon sweep over all 16 indices, back-to-back
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 32'h5353_5353, 4'(i));
            check($sformatf("sweep_rcon_r%0d", i), rcon, {rc_exp[i], 24'h0});
            check($sformatf("sweep_valid_r%0d", i), {31'h0, out_valid}, 32'h1);
            check($sformatf("sweep_state_r%0d", i), state_out, 32'heded_eded);
        end

        // Hold: one request, then en=0 with random and unknown inputs
        step(1'b1, 32'hcf4f_3c09, 4'd10);
        check("hold_req_state", state_out, 32'h8a84_eb01);
        check("hold_req_rcon",  rcon, 32'h3600_0000);
        held_state = 32'h8a84_eb01;
        held_rcon  = 32'h3600_0000;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) step(1'b0, 32'hxxxx_xxxx, 4'bxxxx);
            else        step(1'b0, $urandom, 4'($urandom_range(15, 0)));
            check($sformatf("hold_state_%0d", i), state_out, held_state);
            check($sformatf("hold_rcon_%0d", i),  rcon, held_rcon);
            check($sformatf("hold_valid_%0d", i), {31'h0, out_valid}, 32'h0);
        end

        // Async reset in the middle of a cycle with a request pending
        step(1'b1, 32'h0001_53ff, 4'd3);
        check("pre_rst_valid", {31'h0, out_valid}, 32'h1);
        en    = 1'b1;
        state = 32'hcf4f_3c09;
        r     = 4'd9;
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_state", state_out, 32'h0);
        check("async_rst_rcon",  rcon, 32'h0);
        check("async_rst_valid", {31'h0, out_valid}, 32'h0);
        @(posedge clk);
        #1;
        check("in_rst_valid", {31'h0, out_valid}, 32'h0);
        check("in_rst_state", state_out, 32'h0);
        rst_n = 1'b1;
        step(1'b0, 32'hcf4f_3c09, 4'd9);
        check("post_rst_idle_valid", {31'h0, out_valid}, 32'h0);
        check("post_rst_idle_state", state_out, 32'h0);
        step(1'b1, 32'h0000_0000, 4'd2);
        check("post_rst_state", state_out, 32'h6363_6363);
        check("post_rst_rcon",  rcon, 32'h0200_0000);
        check("post_rst_valid", {31'h0, out_valid}, 32'h1);

        // All byte values replicated across the four lanes
        for (int i = 0; i < 256; i++) begin
            w = {4{8'(i)}};
            step(1'b1, w, 4'd1);
            check($sformatf("exh_%02h", i), state_out,
                  {ref_tab[i], ref_tab[i], ref_tab[i], ref_tab[i]});
        end

        step(1'b0, 32'h0, 4'd0);
        check("end_valid", {31'h0, out_valid}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
